lcd_bus_seq: RTL

Parametrised successor to the single-panel UC1611 init engine. Drives an 8080-style write-only LCD bus (cs, cd, write, data) from three sources: an external init-command table run at power-up, a pixel/data stream accepted over a valid/ready handshake while the display is on, and a shutdown command sent when the display is switched off. Sits between the PPU pixel pipeline and the LCD pins.

---
 rtl/lcd_bus_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_seq.sv
// 8080-style write-only LCD bus sequencer: init table, pixel stream, shutdown.
// Define LCD_BUS_SEQ_CMD_INJECT_EN to enable the command inject port.
module lcd_bus_seq #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned INIT_LEN  = 16,
  parameter int unsigned DELAY_W   = 16,
  parameter int unsigned PHASE_LEN = 1,
  parameter logic [DATA_W-1:0] OFF_CMD = DATA_W'(8'he2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_on,
  output logic [7:0]        init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [DATA_W-1:0] lcd_data,
  output logic              lcd_cd,
  output logic              lcd_write,
  output logic              lcd_cs,
  output logic              lcd_read,
  output logic              lcd_vled,
  output logic              busy,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready
);

  typedef enum logic [2:0] {
    S_OFF, S_WAIT, S_INIT, S_ON, S_UNINIT
  } state_e;

  localparam logic [3:0] PL_M1 = 4'(PHASE_LEN - 1);
  localparam logic [8:0] LEN   = 9'(INIT_LEN);

  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  dly_q, dly_d;
  logic [8:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                cd_q, cd_d;
  logic                act_q, act_d;
  logic [2:0]          ph_q, ph_d;
  logic [3:0]          pcnt_q, pcnt_d;
  logic                start, last, free, crdy;

  // ph_q: 0 = setup clock, 1..4 = P0..P3
  assign last = act_q && (ph_q == 3'd4) && (pcnt_q == PL_M1);
  assign free = !act_q || last;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    idx_d     = idx_q;
    data_d    = data_q;
    cd_d      = cd_q;
    start     = 1'b0;
    pix_ready = 1'b0;
    crdy      = 1'b0;
    unique case (state_q)
      S_OFF: if (disp_on) begin
        state_d = S_WAIT;
        dly_d   = '0;
        idx_d   = '0;
        cd_d    = 1'b0;
      end
      S_WAIT: begin
        dly_d = dly_q + 1'b1;
        if (!disp_on) begin
          state_d = S_UNINIT;
          data_d  = OFF_CMD;
          cd_d    = 1'b0;
          start   = 1'b1;
        end else if (&dly_d[DELAY_W-1 -: 2]) begin
          state_d = S_INIT;
          idx_d   = 9'd1;
          data_d  = init_data;
          cd_d    = 1'b0;
          start   = 1'b1;
        end
      end
      S_INIT: if (last) begin
        if (!disp_on) begin
          state_d = S_UNINIT;
          data_d  = OFF_CMD;
          cd_d    = 1'b0;
          start   = 1'b1;
        end else if (idx_q == LEN) begin
          state_d = S_ON;
          cd_d    = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          data_d = init_data;
          start  = 1'b1;
        end
      end
      S_ON: if (free) begin
        cd_d = 1'b1;
        if (!disp_on) begin
          state_d = S_UNINIT;
          data_d  = OFF_CMD;
          cd_d    = 1'b0;
          start   = 1'b1;
`ifdef LCD_BUS_SEQ_CMD_INJECT_EN
        end else if (cmd_valid) begin
          crdy   = 1'b1;
          data_d = cmd_data;
          cd_d   = 1'b0;
          start  = 1'b1;
`endif
        end else begin
          crdy      = 1'b1;
          pix_ready = 1'b1;
          if (pix_valid) begin
            data_d = pix_data;
            start  = 1'b1;
          end
        end
      end
      S_UNINIT: if (last) begin
        state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    act_d  = act_q;
    ph_d   = ph_q;
    pcnt_d = pcnt_q;
    if (start) begin
      act_d  = 1'b1;
      ph_d   = 3'd0;
      pcnt_d = 4'd0;
    end else if (act_q) begin
      if (ph_q == 3'd0) begin
        ph_d = 3'd1;
      end else if (pcnt_q == PL_M1) begin
        pcnt_d = 4'd0;
        if (ph_q == 3'd4) act_d = 1'b0;
        else ph_d = ph_q + 3'd1;
      end else begin
        pcnt_d = pcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      dly_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cd_q    <= 1'b0;
      act_q   <= 1'b0;
      ph_q    <= 3'd0;
      pcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cd_q    <= cd_d;
      act_q   <= act_d;
      ph_q    <= ph_d;
      pcnt_q  <= pcnt_d;
    end
  end

`ifdef LCD_BUS_SEQ_CMD_INJECT_EN
  assign cmd_ready = crdy;
`else
  logic unused_cmd;
  assign unused_cmd = ^{cmd_valid, cmd_data, crdy};
  assign cmd_ready  = 1'b0;
`endif

  assign init_addr = idx_q[7:0];
  assign lcd_data  = data_q;
  assign lcd_cd    = cd_q;
  assign lcd_cs    = act_q && (ph_q >= 3'd1) && (ph_q <= 3'd3);
  assign lcd_write = act_q && (ph_q == 3'd2);
  assign lcd_read  = 1'b0;
  assign lcd_vled  = disp_on;
  assign busy      = !((state_q == S_OFF) || ((state_q == S_ON) && !act_q));

endmodule
